// File: rtl/fixpoint_pkg.sv
// Shared types for the bounded reachability fixpoint controller.
package fixpoint_pkg;
   typedef enum logic [1:0] {
      FIXPOINT = 2'd0,
      BUG      = 2'd1,
      TIMEOUT  = 2'd2,
      ABORT    = 2'd3
   } result_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      STEP = 2'd1,
      DONE = 2'd2
   } state_e;
endpackage

// File: rtl/fixpoint_step.sv
// One image step of the monotone shift-left step relation, plus convergence detect.
module fixpoint_step #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] r_i,
   input  logic [WIDTH-1:0] allow_mask_i,
   output logic [WIDTH-1:0] nxt_o,
   output logic             converged_o
);
   assign nxt_o       = r_i | ((r_i << 1) & allow_mask_i);
   assign converged_o = (nxt_o == r_i);
endmodule

// File: rtl/fixpoint_iter_ctrl.sv
// Bounded forward-reachability fixpoint controller, one image step per clock.
// Optional trace outputs are enabled by defining FIXPOINT_TRACE_EN.
module fixpoint_iter_ctrl
   import fixpoint_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int MAX_ITER = 16,
   parameter int CNT_W    = $clog2(MAX_ITER + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [WIDTH-1:0] init_frame,
   input  logic [WIDTH-1:0] allow_mask,
   input  logic [WIDTH-1:0] bad_mask,
   output logic             busy,
   output logic             done,
   output logic [1:0]       result,
   output logic [WIDTH-1:0] frame,
   output logic [CNT_W-1:0] iter_cnt
`ifdef FIXPOINT_TRACE_EN
   ,
   output logic             trace_valid,
   output logic [WIDTH-1:0] trace_frame
`endif
);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_ITER);

   state_e           state_q;
   result_e          result_q, result_d;
   logic [WIDTH-1:0] frame_q, allow_q, bad_q;
   logic [CNT_W-1:0] cnt_q;
   logic             busy_q, done_q;
   logic             term_d, step_d;
   logic [WIDTH-1:0] nxt;
   logic             converged;

   fixpoint_step #(.WIDTH(WIDTH)) u_step (
      .r_i          (frame_q),
      .allow_mask_i (allow_q),
      .nxt_o        (nxt),
      .converged_o  (converged)
   );

   // Termination priority: abort, bad hit, convergence, iteration bound.
   always_comb begin
      result_d = result_q;
      term_d   = 1'b1;
      step_d   = 1'b0;
      if (abort)                      result_d = ABORT;
      else if ((frame_q & bad_q) != '0) result_d = BUG;
      else if (converged)             result_d = FIXPOINT;
      else if (cnt_q == MAX_CNT)      result_d = TIMEOUT;
      else begin
         term_d = 1'b0;
         step_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         result_q <= FIXPOINT;
         frame_q  <= '0;
         allow_q  <= '0;
         bad_q    <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  allow_q <= allow_mask;
                  bad_q   <= bad_mask;
                  frame_q <= init_frame;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= STEP;
               end
            end
            STEP: begin
               if (term_d) begin
                  result_q <= result_d;
                  done_q   <= 1'b1;
                  state_q  <= DONE;
               end else if (step_d) begin
                  frame_q <= nxt;
                  cnt_q   <= cnt_q + CNT_W'(1);
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign result   = result_q;
   assign frame    = frame_q;
   assign iter_cnt = cnt_q;

`ifdef FIXPOINT_TRACE_EN
   assign trace_valid = (state_q == STEP) && step_d;
   assign trace_frame = nxt;
`endif
endmodule

// File: tb/tb_fixpoint_iter_ctrl.sv
// Scoreboard bench: directed runs push expected outcomes, monitors check on done.
module tb_fixpoint_iter_ctrl;
   typedef struct {
      int res;
      int frame;
      int iter;
      int cyc;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int tests = 0;
   int fails = 0;
   exp_t qa[$];
   exp_t qb[$];

   logic       rst = 1'b1;
   logic       start_a = 1'b0, abort_a = 1'b0;
   logic [7:0] init_a = '0, allow_a = '0, bad_a = '0;
   logic       busy_a, done_a;
   logic [1:0] result_a;
   logic [7:0] frame_a;
   logic [4:0] iter_a;

   logic       start_b = 1'b0, abort_b = 1'b0;
   logic [7:0] init_b = '0, allow_b = '0, bad_b = '0;
   logic       busy_b, done_b;
   logic [1:0] result_b;
   logic [7:0] frame_b;
   logic [2:0] iter_b;

`ifdef FIXPOINT_TRACE_EN
   logic       tv_a, tv_b;
   logic [7:0] tf_a, tf_b;
`endif

   fixpoint_iter_ctrl #(.WIDTH(8), .MAX_ITER(16)) dut_a (
      .clk(clk), .rst(rst), .start(start_a), .abort(abort_a),
      .init_frame(init_a), .allow_mask(allow_a), .bad_mask(bad_a),
      .busy(busy_a), .done(done_a), .result(result_a),
      .frame(frame_a), .iter_cnt(iter_a)
`ifdef FIXPOINT_TRACE_EN
      , .trace_valid(tv_a), .trace_frame(tf_a)
`endif
   );

   fixpoint_iter_ctrl #(.WIDTH(8), .MAX_ITER(4)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .abort(abort_b),
      .init_frame(init_b), .allow_mask(allow_b), .bad_mask(bad_b),
      .busy(busy_b), .done(done_b), .result(result_b),
      .frame(frame_b), .iter_cnt(iter_b)
`ifdef FIXPOINT_TRACE_EN
      , .trace_valid(tv_b), .trace_frame(tf_b)
`endif
   );

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   // Monitors: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (done_a === 1'b1) begin
         if (qa.size() == 0) chk("a_unexpected_done", 1, 0);
         else begin
            exp_t e;
            e = qa.pop_front();
            chk("a_result", int'(result_a), e.res);
            chk("a_frame", int'(frame_a), e.frame);
            chk("a_iter", int'(iter_a), e.iter);
            chk("a_done_cycle", cyc, e.cyc);
            chk("a_busy_in_done", int'(busy_a), 1);
         end
      end
   end

   always @(negedge clk) begin
      if (done_b === 1'b1) begin
         if (qb.size() == 0) chk("b_unexpected_done", 1, 0);
         else begin
            exp_t e;
            e = qb.pop_front();
            chk("b_result", int'(result_b), e.res);
            chk("b_frame", int'(frame_b), e.frame);
            chk("b_iter", int'(iter_b), e.iter);
            chk("b_done_cycle", cyc, e.cyc);
         end
      end
   end

   // Drive start for one cycle; lat is the done cycle relative to the start cycle.
   task automatic issue_a(input logic [7:0] ini, input logic [7:0] al, input logic [7:0] bd,
                          input int res, input int fr, input int it, input int lat, input bit push);
      @(negedge clk);
      start_a = 1'b1; init_a = ini; allow_a = al; bad_a = bd;
      if (push) qa.push_back('{res, fr, it, cyc + lat});
      @(negedge clk);
      start_a = 1'b0;
   endtask

   task automatic wait_idle_a();
      bit ok = 1'b0;
      for (int k = 0; k < 100; k++) begin
         if (busy_a === 1'b0) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      chk("a_idle_timeout", int'(ok), 1);
   endtask

   task automatic chk_reset_a(input string tag);
      chk({tag, "_busy"}, int'(busy_a), 0);
      chk({tag, "_done"}, int'(done_a), 0);
      chk({tag, "_result"}, int'(result_a), 0);
      chk({tag, "_frame"}, int'(frame_a), 0);
      chk({tag, "_iter"}, int'(iter_a), 0);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk_reset_a("rst_a");
      chk("rst_b_busy", int'(busy_b), 0);
      chk("rst_b_iter", int'(iter_b), 0);
      rst = 1'b0;

      // Full fill to 0xFF, converges after 7 steps.
      issue_a(8'h01, 8'hFF, 8'h00, 0, 8'hFF, 7, 9, 1'b1);
      wait_idle_a();
      // Bad bit 4 reached after 4 steps.
      issue_a(8'h01, 8'hFF, 8'h10, 1, 8'h1F, 4, 6, 1'b1);
      wait_idle_a();
      // Growth blocked at bit 3.
      issue_a(8'h01, 8'hF7, 8'h00, 0, 8'h07, 2, 4, 1'b1);
      wait_idle_a();
      // Bad bit already present in the initial frame.
      issue_a(8'h80, 8'hFF, 8'h80, 1, 8'h80, 0, 2, 1'b1);
      wait_idle_a();

      // Iteration bound on the MAX_ITER=4 instance.
      @(negedge clk);
      start_b = 1'b1; init_b = 8'h01; allow_b = 8'hFF; bad_b = 8'h00;
      qb.push_back('{2, 8'h1F, 4, cyc + 6});
      @(negedge clk);
      start_b = 1'b0;
      repeat (10) @(negedge clk);
      chk("b_idle_after_timeout", int'(busy_b), 0);

      // Abort in the third STEP cycle.
      issue_a(8'h01, 8'hFF, 8'h00, 3, 8'h07, 2, 4, 1'b1);
      @(negedge clk);
      @(negedge clk);
      abort_a = 1'b1;
      @(negedge clk);
      abort_a = 1'b0;
      wait_idle_a();
      // Abort in IDLE has no effect.
      abort_a = 1'b1;
      repeat (2) @(negedge clk);
      abort_a = 1'b0;
      chk("a_abort_idle_busy", int'(busy_a), 0);
      chk("a_result_held", int'(result_a), 3);

      // Reset mid-run clears everything.
      issue_a(8'h01, 8'hFF, 8'h00, 0, 0, 0, 0, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk_reset_a("midrst_a");
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("a_idle_after_rst", int'(busy_a), 0);

      // Start while busy is ignored.
      issue_a(8'h01, 8'hFF, 8'h00, 0, 8'hFF, 7, 9, 1'b1);
      @(negedge clk);
      start_a = 1'b1; init_a = 8'h80; bad_a = 8'h80;
      @(negedge clk);
      start_a = 1'b0;
      wait_idle_a();
      repeat (3) @(negedge clk);
      chk("a_result_after_busy_start", int'(result_a), 0);
      chk("a_frame_after_busy_start", int'(frame_a), 8'hFF);

      repeat (5) @(negedge clk);
      chk("a_queue_drained", qa.size(), 0);
      chk("b_queue_drained", qb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
